// File: rtl/wt_cache_pkg.sv
// Shared write-through dcache types, including the SHiP predictor's counter and metadata types.
package wt_cache_pkg;

   localparam int unsigned DCACHE_NUM_WORDS = 256;
   localparam int unsigned DCACHE_SET_ASSOC = 4;
   localparam int unsigned SHIP_SIG_WIDTH   = 8;
   localparam int unsigned SHIP_CTR_WIDTH   = 2;

   typedef logic [SHIP_SIG_WIDTH-1:0] ship_sig_t;
   typedef logic [SHIP_CTR_WIDTH-1:0] ship_ctr_t;

   typedef struct packed {
      logic      valid;
      logic      outcome;
      ship_sig_t sig;
   } ship_meta_t;

   localparam ship_ctr_t SHIP_CTR_INIT = 2'b01;
   localparam ship_ctr_t SHIP_CTR_MAX  = 2'b11;

   typedef enum logic {
      SHIP_CLEAR,
      SHIP_IDLE
   } ship_state_e;

endpackage

// File: rtl/wt_dcache_ship_meta.sv
// Per-line SHiP metadata storage: fill port, hit port (sets outcome) and a whole-set clear port.
module wt_dcache_ship_meta
   import wt_cache_pkg::*;
#(
   parameter int unsigned NUM_SETS = DCACHE_NUM_WORDS,
   parameter int unsigned WAYS     = DCACHE_SET_ASSOC
) (
   input  logic                        clk_i,
   input  logic                        clr_en_i,
   input  logic [$clog2(NUM_SETS)-1:0] clr_idx_i,
   input  logic                        fill_we_i,
   input  logic [$clog2(NUM_SETS)-1:0] fill_idx_i,
   input  logic [$clog2(WAYS)-1:0]     fill_way_i,
   input  ship_meta_t                  fill_wdata_i,
   output ship_meta_t                  fill_rdata_o,
   input  logic                        hit_we_i,
   input  logic [$clog2(NUM_SETS)-1:0] hit_idx_i,
   input  logic [$clog2(WAYS)-1:0]     hit_way_i,
   output ship_meta_t                  hit_rdata_o
);

   ship_meta_t mem_q [NUM_SETS][WAYS];

   assign fill_rdata_o = mem_q[fill_idx_i][fill_way_i];
   assign hit_rdata_o  = mem_q[hit_idx_i][hit_way_i];

   // No reset: contents are only trusted after the clear sweep has covered every set.
   always_ff @(posedge clk_i) begin
      if (clr_en_i) begin
         for (int w = 0; w < WAYS; w++) begin
            mem_q[clr_idx_i][w] <= '0;
         end
      end
      if (hit_we_i) begin
         mem_q[hit_idx_i][hit_way_i].outcome <= 1'b1;
      end
      if (fill_we_i) begin
         mem_q[fill_idx_i][fill_way_i] <= fill_wdata_i;
      end
   end

endmodule

// File: rtl/wt_dcache_ship_pred.sv
// SHiP insertion predictor for the write-through dcache: SHCT, training and metadata clear FSM.
// Optional counters enabled by macro WT_DCACHE_SHIP_STATS_EN.
//   state      | meaning
//   SHIP_CLEAR | sweeping metadata one set per cycle, training blocked, busy_o high
//   SHIP_IDLE  | normal operation, hits and fills train the SHCT
module wt_dcache_ship_pred
   import wt_cache_pkg::*;
#(
   parameter int unsigned NUM_SETS  = DCACHE_NUM_WORDS,
   parameter int unsigned WAYS      = DCACHE_SET_ASSOC,
   parameter int unsigned SIG_WIDTH = SHIP_SIG_WIDTH,
   parameter int unsigned CTR_WIDTH = SHIP_CTR_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_i,
   output logic                        busy_o,
   input  logic                        pred_req_i,
   input  logic [SIG_WIDTH-1:0]        pred_sig_i,
   output logic                        pred_valid_o,
   output logic [CTR_WIDTH-1:0]        pred_o,
   input  logic                        fill_i,
   input  logic [$clog2(NUM_SETS)-1:0] fill_idx_i,
   input  logic [$clog2(WAYS)-1:0]     fill_way_i,
   input  logic [SIG_WIDTH-1:0]        fill_sig_i,
   input  logic                        hit_i,
   input  logic [$clog2(NUM_SETS)-1:0] hit_idx_i,
   input  logic [$clog2(WAYS)-1:0]     hit_way_i,
   output logic [31:0]                 stat_dead_pred_o,
   output logic [31:0]                 stat_doa_evict_o
);

   localparam int unsigned IDX_W      = $clog2(NUM_SETS);
   localparam int unsigned SHCT_DEPTH = 2**SIG_WIDTH;

   ship_state_e      state_q;
   logic [IDX_W-1:0] set_cnt_q;
   ship_ctr_t        shct_q [SHCT_DEPTH];
   ship_meta_t       fill_meta, hit_meta, fill_wdata;
   logic             train, same_line, fill_en, hit_en, inc_raw, dec_raw, collide;

   assign train     = (state_q == SHIP_IDLE) && !flush_i;
   assign same_line = fill_i && (hit_idx_i == fill_idx_i) && (hit_way_i == fill_way_i);
   assign fill_en   = train && fill_i;
   assign hit_en    = train && hit_i && !same_line;
   assign inc_raw   = hit_en && hit_meta.valid && !hit_meta.outcome;
   assign dec_raw   = fill_en && fill_meta.valid && !fill_meta.outcome;
   // Opposite updates to one counter in the same cycle cancel out.
   assign collide   = inc_raw && dec_raw && (hit_meta.sig == fill_meta.sig);

   assign fill_wdata = '{valid: 1'b1, outcome: 1'b0, sig: ship_sig_t'(fill_sig_i)};

   wt_dcache_ship_meta #(
      .NUM_SETS (NUM_SETS),
      .WAYS     (WAYS)
   ) i_meta (
      .clk_i        (clk_i),
      .clr_en_i     (state_q == SHIP_CLEAR),
      .clr_idx_i    (set_cnt_q),
      .fill_we_i    (fill_en),
      .fill_idx_i   (fill_idx_i),
      .fill_way_i   (fill_way_i),
      .fill_wdata_i (fill_wdata),
      .fill_rdata_o (fill_meta),
      .hit_we_i     (inc_raw),
      .hit_idx_i    (hit_idx_i),
      .hit_way_i    (hit_way_i),
      .hit_rdata_o  (hit_meta)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= SHIP_CLEAR;
         set_cnt_q <= '0;
         busy_o    <= 1'b1;
      end else begin
         case (state_q)
            SHIP_CLEAR: begin
               if (flush_i) begin
                  set_cnt_q <= '0;
               end else if (set_cnt_q == IDX_W'(NUM_SETS-1)) begin
                  state_q   <= SHIP_IDLE;
                  busy_o    <= 1'b0;
                  set_cnt_q <= '0;
               end else begin
                  set_cnt_q <= set_cnt_q + 1'b1;
               end
            end
            SHIP_IDLE: begin
               if (flush_i) begin
                  state_q   <= SHIP_CLEAR;
                  busy_o    <= 1'b1;
                  set_cnt_q <= '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < SHCT_DEPTH; i++) begin
            shct_q[i] <= SHIP_CTR_INIT;
         end
      end else if (!collide) begin
         if (inc_raw && shct_q[hit_meta.sig] != SHIP_CTR_MAX) begin
            shct_q[hit_meta.sig] <= shct_q[hit_meta.sig] + ship_ctr_t'(1);
         end
         if (dec_raw && shct_q[fill_meta.sig] != '0) begin
            shct_q[fill_meta.sig] <= shct_q[fill_meta.sig] - ship_ctr_t'(1);
         end
      end
   end

   // Read happens before this cycle's training write lands.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pred_valid_o <= 1'b0;
         pred_o       <= '0;
      end else begin
         pred_valid_o <= pred_req_i;
         pred_o       <= pred_req_i ? shct_q[pred_sig_i] : '0;
      end
   end

`ifdef WT_DCACHE_SHIP_STATS_EN
   logic [31:0] dead_q, doa_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dead_q <= '0;
         doa_q  <= '0;
      end else begin
         if (pred_valid_o && pred_o == '0 && dead_q != '1) begin
            dead_q <= dead_q + 32'd1;
         end
         if (dec_raw && doa_q != '1) begin
            doa_q <= doa_q + 32'd1;
         end
      end
   end

   assign stat_dead_pred_o = dead_q;
   assign stat_doa_evict_o = doa_q;
`else
   assign stat_dead_pred_o = '0;
   assign stat_doa_evict_o = '0;
`endif

endmodule

// File: tb/tb_wt_dcache_ship_pred.sv
// Directed self-checking bench for the SHiP predictor: sweep timing, training, collisions, flush.
module tb_wt_dcache_ship_pred;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        busy_o;
   logic        pred_req_i = 1'b0;
   logic [7:0]  pred_sig_i = '0;
   logic        pred_valid_o;
   logic [1:0]  pred_o;
   logic        fill_i = 1'b0;
   logic [7:0]  fill_idx_i = '0;
   logic [1:0]  fill_way_i = '0;
   logic [7:0]  fill_sig_i = '0;
   logic        hit_i = 1'b0;
   logic [7:0]  hit_idx_i = '0;
   logic [1:0]  hit_way_i = '0;
   logic [31:0] stat_dead_pred_o;
   logic [31:0] stat_doa_evict_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   wt_dcache_ship_pred dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .flush_i          (flush_i),
      .busy_o           (busy_o),
      .pred_req_i       (pred_req_i),
      .pred_sig_i       (pred_sig_i),
      .pred_valid_o     (pred_valid_o),
      .pred_o           (pred_o),
      .fill_i           (fill_i),
      .fill_idx_i       (fill_idx_i),
      .fill_way_i       (fill_way_i),
      .fill_sig_i       (fill_sig_i),
      .hit_i            (hit_i),
      .hit_idx_i        (hit_idx_i),
      .hit_way_i        (hit_way_i),
      .stat_dead_pred_o (stat_dead_pred_o),
      .stat_doa_evict_o (stat_doa_evict_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic predict(input logic [7:0] sig, input logic [1:0] exp, input string tag);
      pred_req_i = 1'b1;
      pred_sig_i = sig;
      cycle();
      pred_req_i = 1'b0;
      chk({tag, "_valid"}, {31'd0, pred_valid_o}, 32'd1);
      chk(tag, {30'd0, pred_o}, {30'd0, exp});
   endtask

   task automatic do_fill(input logic [7:0] idx, input logic [1:0] way, input logic [7:0] sig);
      fill_i = 1'b1; fill_idx_i = idx; fill_way_i = way; fill_sig_i = sig;
      cycle();
      fill_i = 1'b0;
   endtask

   task automatic do_hit(input logic [7:0] idx, input logic [1:0] way);
      hit_i = 1'b1; hit_idx_i = idx; hit_way_i = way;
      cycle();
      hit_i = 1'b0;
   endtask

   int n;
   logic [31:0] exp_dead, exp_doa;

   initial begin
`ifdef WT_DCACHE_SHIP_STATS_EN
      exp_dead = 32'd3;
      exp_doa  = 32'd4;
`else
      exp_dead = 32'd0;
      exp_doa  = 32'd0;
`endif
      // Reset state
      cycle();
      cycle();
      chk("rst_busy", {31'd0, busy_o}, 32'd1);
      chk("rst_pred_valid", {31'd0, pred_valid_o}, 32'd0);
      chk("rst_pred", {30'd0, pred_o}, 32'd0);
      chk("rst_stat_dead", stat_dead_pred_o, 32'd0);
      chk("rst_stat_doa", stat_doa_evict_o, 32'd0);
      rst_i = 1'b0;

      n = 0;
      while (busy_o && n < 1000) begin
         cycle();
         n++;
      end
      chk("sweep_len", n, 32'd256);

      predict(8'h12, 2'd1, "pred_init");
      cycle();
      chk("pred_valid_drop", {31'd0, pred_valid_o}, 32'd0);

      // One increment per line regardless of repeat hits
      do_fill(8'd5, 2'd2, 8'h12);
      do_hit(8'd5, 2'd2);
      do_hit(8'd5, 2'd2);
      predict(8'h12, 2'd2, "pred_hit_once");

      // Dead eviction decrements
      do_fill(8'd7, 2'd0, 8'h34);
      do_fill(8'd7, 2'd0, 8'h35);
      predict(8'h34, 2'd0, "pred_dead_evict");

      // Saturation high
      for (int w = 0; w < 4; w++) do_fill(8'd10, 2'(w), 8'h12);
      for (int w = 0; w < 4; w++) do_hit(8'd10, 2'(w));
      predict(8'h12, 2'd3, "pred_sat_hi");

      // Saturation low
      do_fill(8'd7, 2'd1, 8'h34);
      do_fill(8'd7, 2'd1, 8'h36);
      predict(8'h34, 2'd0, "pred_sat_lo");

      // Increment and decrement on one entry cancel
      do_fill(8'd20, 2'd0, 8'h40);
      do_fill(8'd21, 2'd0, 8'h40);
      hit_i = 1'b1; hit_idx_i = 8'd20; hit_way_i = 2'd0;
      fill_i = 1'b1; fill_idx_i = 8'd21; fill_way_i = 2'd0; fill_sig_i = 8'h41;
      cycle();
      hit_i = 1'b0; fill_i = 1'b0;
      predict(8'h40, 2'd1, "pred_collide");
      do_fill(8'd20, 2'd0, 8'h42);
      predict(8'h40, 2'd1, "pred_hit_applied");

      // Hit and fill to same line: fill wins
      do_fill(8'd3, 2'd1, 8'h50);
      hit_i = 1'b1; hit_idx_i = 8'd3; hit_way_i = 2'd1;
      fill_i = 1'b1; fill_idx_i = 8'd3; fill_way_i = 2'd1; fill_sig_i = 8'h51;
      cycle();
      hit_i = 1'b0; fill_i = 1'b0;
      predict(8'h50, 2'd0, "pred_same_line");
      do_hit(8'd3, 2'd1);
      predict(8'h51, 2'd2, "pred_fill_written");

      // Flush, restart at sweep cycle 100, hits ignored, predictions served
      do_fill(8'd30, 2'd0, 8'h60);
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      chk("flush_busy", {31'd0, busy_o}, 32'd1);
      hit_i = 1'b1; hit_idx_i = 8'd30; hit_way_i = 2'd0;
      pred_req_i = 1'b1; pred_sig_i = 8'h60;
      for (int i = 0; i < 100; i++) cycle();
      chk("busy_at_100", {31'd0, busy_o}, 32'd1);
      chk("pred_in_sweep", {30'd0, pred_o}, 32'd1);
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      n = 0;
      while (busy_o && n < 1000) begin
         cycle();
         n++;
      end
      chk("sweep_restart_len", n, 32'd256);
      hit_i = 1'b0; pred_req_i = 1'b0;
      do_hit(8'd30, 2'd0);
      do_fill(8'd30, 2'd0, 8'h61);
      predict(8'h60, 2'd1, "pred_after_flush");
      predict(8'h12, 2'd3, "pred_shct_kept");

      chk("stat_dead", stat_dead_pred_o, exp_dead);
      chk("stat_doa", stat_doa_evict_o, exp_doa);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wt_dcache_ship_pred.md
Name: wt_dcache_ship_pred

Overview:
Signature-based hit predictor (SHiP) for the write-through dcache. It produces the 2-bit insertion prediction that the SHiP-aware PLRU replacement stage consumes on a miss fill.
- Holds a Signature History Counter Table (SHCT) of saturating counters.
- Holds per-line metadata: valid, outcome, signature.
- Trains the SHCT from dcache hits and evictions.
- Sits between the miss unit (fill and signature source) and the replacement stage.

Parameters:
NUM_SETS, DCACHE_NUM_WORDS (256), number of cache sets
WAYS, DCACHE_SET_ASSOC (4), associativity
SIG_WIDTH, 8, signature width; SHCT depth is 2**SIG_WIDTH
CTR_WIDTH, 2, SHCT counter width; must be 2 to match the replacement-stage input

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
flush_i  in  1  clear all line metadata
busy_o  out  1  metadata clear sweep in progress
pred_req_i  in  1  prediction request (miss issued)
pred_sig_i  in  SIG_WIDTH  signature of the missing line
pred_valid_o  out  1  prediction valid
pred_o  out  CTR_WIDTH  SHCT counter value; 0 = predicted dead
fill_i  in  1  line fill
fill_idx_i  in  $clog2(NUM_SETS)  fill set
fill_way_i  in  $clog2(WAYS)  fill (victim) way
fill_sig_i  in  SIG_WIDTH  signature of the new line
hit_i  in  1  dcache hit
hit_idx_i  in  $clog2(NUM_SETS)  hit set
hit_way_i  in  $clog2(WAYS)  hit way
stat_dead_pred_o  out  32  count of predictions equal to 0 (optional feature)
stat_doa_evict_o  out  32  count of dead-on-arrival evictions (optional feature)

Behaviour:
Reset and outputs
- Reset is asynchronous, active-high; one clock.
- On rst_i: every SHCT entry = 2'b01; FSM = CLEAR with set counter 0; busy_o = 1; pred_valid_o = 0; pred_o = 0; stats = 0.

Prediction
- Latency 1 cycle: pred_valid_o is pred_req_i delayed one cycle.
- pred_o = SHCT[pred_sig_i] as held in the request cycle, before that cycle's training update.
- Predictions are served during busy_o.

FSM states and transitions
- CLEAR: writes meta[set][all ways] = 0 for one set per cycle. Exits to IDLE after set NUM_SETS-1 is cleared. busy_o is therefore high for exactly NUM_SETS cycles.
- IDLE: on flush_i, go to CLEAR with set counter 0.
- flush_i while in CLEAR restarts the sweep at set 0.
- hit_i and fill_i are ignored while busy_o = 1 and in the cycle flush_i is high.

Training (IDLE only; metadata read and written in the same cycle)
- Hit: if meta[hit_idx_i][hit_way_i] is valid and outcome = 0, then SHCT[meta.sig] += 1 (saturate at 3) and outcome = 1. Hits on invalid lines and repeat hits change nothing.
- Fill: if the victim meta is valid and outcome = 0, then SHCT[victim.sig] -= 1 (saturate at 0). Then meta = {valid=1, outcome=0, sig=fill_sig_i}.

Simultaneous events
- Hit and fill to the same (idx, way): fill wins, hit dropped; the eviction decision uses the stored outcome.
- Increment and decrement to the same SHCT entry in one cycle: entry unchanged.
- Hit and fill to different lines in one cycle: both applied.

Optional Feature:
Macro: WT_DCACHE_SHIP_STATS_EN
- Defined: stat_dead_pred_o increments when pred_valid_o = 1 and pred_o = 0. stat_doa_evict_o increments on every SHCT decrement caused by eviction. Both are 32-bit, saturate at all-ones, and are cleared only by rst_i.
- Undefined: both outputs tied to 0 and no counter flops.

Decomposition:
wt_cache_pkg gains:
- ship_sig_t (SIG_WIDTH bits)
- ship_ctr_t (CTR_WIDTH bits)
- ship_meta_t struct {valid, outcome, sig}
- constants SHIP_CTR_INIT = 2'b01 and SHIP_CTR_MAX = 2'b11

Sub-module wt_dcache_ship_meta: per-set metadata storage with one read/write port for fill, one for hit, and a whole-set clear port driven by the sweep. The SHCT and FSM stay in the top level.

Test Plan:
- Release rst_i -> busy_o high exactly 256 cycles; pred_req_i with sig 0x12 -> pred_valid_o=1, pred_o=1 next cycle.
- Fill idx 5 way 2 sig 0x12; hit idx 5 way 2 twice -> SHCT[0x12] = 2 (single increment); predict 0x12 -> 2.
- Fill idx 7 way 0 sig 0x34, then fill idx 7 way 0 sig 0x35 with no hit -> SHCT[0x34] 1->0; predict 0x34 -> 0; stat_dead_pred_o = 1 with WT_DCACHE_SHIP_STATS_EN.
- Four first-hits on fresh lines with sig 0x12 -> counter saturates at 3. Decrement at 0 -> stays 0.
- Same cycle: first-hit on a line with sig 0x40 plus dead eviction of another line with sig 0x40 -> SHCT[0x40] unchanged. Same cycle hit and fill idx 3 way 1 -> only the fill applied.
- flush_i at sweep cycle 100 -> sweep restarts; busy_o high 256 more cycles; hits during the sweep leave SHCT unchanged; a prediction during the sweep returns the current SHCT value.
